load_store_unit: RTL and testbench

- Data-memory access stage directly upstream of the memory data register; produces the 32-bit ReadData that register captures.
- Accepts one load/store request from the execute stage through a valid/ready handshake.
- Drives a variable-latency data memory with an en/ack handshake, and aligns and sign- or zero-extends load data.
- One transaction in flight at a time; little-endian byte lanes.

---
 rtl/load_store_unit.sv | 197 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage; aligns and extends load data, replicates store data onto byte lanes.
// Latency: accept at edge 0, mem_en from cycle 1, done one cycle after mem_ack; misaligned requests complete in cycle 1.
// Backpressure: req_ready only in IDLE; a stalled memory holds the request until mem_ack (or until timeout when LSU_TIMEOUT_EN is defined).
module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       ReadData,
  output logic              done,
  output logic              misalign,
  output logic              fault,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t            state;
  state_t            stateNext;
  logic              writeQ;
  logic [1:0]        sizeQ;
  logic              signedQ;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       wdataQ;
  logic              misalignQ;
  logic              faultQ;
  logic [31:0]       readDataQ;
  logic              accept;
  logic              reqMisaligned;
  logic              timeoutHit;
  logic [3:0]        laneBe;
  logic [31:0]       laneWdata;
  logic [31:0]       laneWord;
  logic [31:0]       loadData;

  assign accept = req_valid && (state == IDLE);

  // Alignment is judged on the incoming request so a bad one never reaches the memory.
  assign reqMisaligned = (req_size == 2'b11) ||
                         ((req_size == 2'b01) && req_addr[0]) ||
                         ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);
  logic [7:0] waitCnt;

  // The ack-less cycle that brings the count to TIMEOUT ends the access; an ack in that cycle still wins.
  assign timeoutHit = (state == ACCESS) && !mem_ack && (waitCnt == LAST_WAIT);

  // Count ACCESS cycles that pass without an ack; restarts with every accepted request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      waitCnt <= '0;
    end else if (accept) begin
      waitCnt <= '0;
    end else if ((state == ACCESS) && !mem_ack) begin
      waitCnt <= waitCnt + 8'd1;
    end
  end
`else
  logic [7:0] unusedTimeout;
  assign unusedTimeout = 8'(TIMEOUT);
  assign timeoutHit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: DONE always lasts one cycle, so no accept can overlap it.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = reqMisaligned ? DONE : ACCESS;
      ACCESS:  if (mem_ack || timeoutHit) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Latch the request at accept; the memory-side outputs are driven from these copies for the whole access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      writeQ    <= 1'b0;
      sizeQ     <= 2'b00;
      signedQ   <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= '0;
      misalignQ <= 1'b0;
      faultQ    <= 1'b0;
    end else if (accept) begin
      writeQ    <= req_write;
      sizeQ     <= req_size;
      signedQ   <= req_signed;
      addrQ     <= req_addr;
      wdataQ    <= req_wdata;
      misalignQ <= reqMisaligned;
      faultQ    <= 1'b0;
    end else if (timeoutHit) begin
      faultQ    <= 1'b1;
    end
  end

  // Byte enables and lane-replicated store data from the latched size and address.
  always_comb begin
    laneBe    = 4'b1111;
    laneWdata = wdataQ;
    case (sizeQ)
      2'b00: begin
        laneBe    = 4'b0001 << addrQ[1:0];
        laneWdata = {4{wdataQ[7:0]}};
      end
      2'b01: begin
        laneBe    = addrQ[1] ? 4'b1100 : 4'b0011;
        laneWdata = {2{wdataQ[15:0]}};
      end
      default: begin
        laneBe    = 4'b1111;
        laneWdata = wdataQ;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it; words are always at offset 0.
  always_comb begin
    laneWord = mem_rdata >> {addrQ[1:0], 3'b000};
    loadData = laneWord;
    case (sizeQ)
      2'b00:   loadData = {{24{signedQ & laneWord[7]}}, laneWord[7:0]};
      2'b01:   loadData = {{16{signedQ & laneWord[15]}}, laneWord[15:0]};
      default: loadData = laneWord;
    endcase
  end

  // Load result register: only a completed load updates it, so stores, rejects and faults leave it alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readDataQ <= '0;
    end else if ((state == ACCESS) && mem_ack && !writeQ) begin
      readDataQ <= loadData;
    end
  end

  assign ReadData = readDataQ;

  // Outputs decoded from state; memory-side signals are zero outside ACCESS so reset clears them at once.
  always_comb begin
    req_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    misalign  = 1'b0;
    fault     = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      ACCESS: begin
        mem_en    = 1'b1;
        busy      = 1'b1;
        mem_we    = writeQ;
        mem_be    = laneBe;
        mem_addr  = {addrQ[ADDR_W-1:2], 2'b00};
        mem_wdata = laneWdata;
      end
      DONE: begin
        done     = 1'b1;
        misalign = misalignQ;
        fault    = faultQ;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store vectors against a transaction-level model of the access stage.
// Latency: the driver owns the timeline (accept, ack cycle) and tells the model which phase each cycle is in.
// Backpressure: memory stalls are modelled by delaying mem_ack a chosen number of cycles.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] ReadData;
  logic        done;
  logic        misalign;
  logic        fault;
  logic        busy;

  load_store_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ReadData(ReadData), .done(done), .misalign(misalign), .fault(fault), .busy(busy)
  );

  always #5 clock = ~clock;

  int nChecks = 0;
  int nPass   = 0;

  // Model state: the phase of the current cycle plus what the memory side and result must show.
  typedef enum {P_IDLE, P_ACCESS, P_DONE} phase_t;
  phase_t      expPhase = P_IDLE;
  logic        expWe    = 1'b0;
  logic [3:0]  expBe    = 4'h0;
  logic [31:0] expAddr  = 32'h0;
  logic [31:0] expWdata = 32'h0;
  logic [31:0] expRead  = 32'h0;
  logic        expMis   = 1'b0;
  logic        expFault = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic mMis(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0);
  endfunction

  function automatic logic [3:0] mBe(input logic [1:0] size, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] mWdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return (w % 256) * 32'h01010101;
    if (size == 2'd1) return (w % 65536) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] mLoad(input logic [1:0] size, input logic sgn,
                                        input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    v = rd / (32'd1 << (8 * (addr % 4)));
    if (size == 2'd0) begin
      v = v % 256;
      if (sgn && v >= 128) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = v % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  // Every cycle, away from the active edge, all outputs must match the model.
  always @(negedge clock) begin
    chk1("cmp_req_ready", req_ready, expPhase == P_IDLE);
    chk1("cmp_busy",      busy,      expPhase == P_ACCESS);
    chk1("cmp_mem_en",    mem_en,    expPhase == P_ACCESS);
    chk1("cmp_mem_we",    mem_we,    (expPhase == P_ACCESS) && expWe);
    chk("cmp_mem_be",     32'(mem_be),  (expPhase == P_ACCESS) ? 32'(expBe) : 32'h0);
    chk("cmp_mem_addr",   mem_addr,  (expPhase == P_ACCESS) ? expAddr : 32'h0);
    chk("cmp_mem_wdata",  mem_wdata, (expPhase == P_ACCESS) ? expWdata : 32'h0);
    chk1("cmp_done",      done,      expPhase == P_DONE);
    chk1("cmp_misalign",  misalign,  (expPhase == P_DONE) && expMis);
    chk1("cmp_fault",     fault,     (expPhase == P_DONE) && expFault);
    chk("cmp_readdata",   ReadData,  expRead);
  end

  // One request: accept, optional access acked in cycle k, then DONE. Literal arguments are hand-computed.
  task automatic doTxn(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [31:0] rd, input int k,
                       input logic [3:0] lBe, input logic [31:0] lAddr, input logic [31:0] lWd,
                       input logic [31:0] lRead, input logic lMis);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    req_write = 1'($urandom); req_signed = 1'($urandom);
    if (mMis(sz, ad)) begin
      expMis = 1'b1; expPhase = P_DONE;
    end else begin
      expWe = wr; expBe = mBe(sz, ad); expAddr = ad & 32'hFFFFFFFC; expWdata = mWdata(sz, wd);
      expPhase = P_ACCESS;
      @(negedge clock);
      chk("lit_mem_be", 32'(mem_be), 32'(lBe));
      chk("lit_mem_addr", mem_addr, lAddr);
      chk("lit_mem_wdata", mem_wdata, lWd);
      chk1("lit_mem_we", mem_we, wr);
      for (int i = 1; i < k; i++) begin @(posedge clock); #1; end
      mem_ack = 1'b1; mem_rdata = rd;
      @(posedge clock); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (!wr) expRead = mLoad(sz, sg, ad, rd);
      expPhase = P_DONE;
    end
    @(negedge clock);
    chk1("lit_done", done, 1'b1);
    chk1("lit_misalign", misalign, lMis);
    chk("lit_readdata", ReadData, lRead);
    @(posedge clock); #1;
    expPhase = P_IDLE; expMis = 1'b0;
  endtask

  initial begin
    int enCnt;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk1("reset_req_ready", req_ready, 1'b1);
    chk1("reset_mem_en", mem_en, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk("reset_readdata", ReadData, 32'h0);
    @(posedge clock); #1 reset = 1'b1;

    //     wr    sz     sg    addr          wdata         rdata         k  be       addr          wdata         ReadData      mis
    doTxn(1'b0, 2'd2, 1'b0, 32'h00000100, 32'h0,        32'hCAFEBABE, 3, 4'b1111, 32'h00000100, 32'h0,        32'hCAFEBABE, 1'b0);
    doTxn(1'b0, 2'd0, 1'b1, 32'h00000103, 32'h0,        32'h80FF7F01, 1, 4'b1000, 32'h00000100, 32'h0,        32'hFFFFFF80, 1'b0);
    doTxn(1'b0, 2'd0, 1'b0, 32'h00000103, 32'h0,        32'h80FF7F01, 2, 4'b1000, 32'h00000100, 32'h0,        32'h00000080, 1'b0);
    doTxn(1'b1, 2'd1, 1'b0, 32'h00000202, 32'hABCD1234, 32'h55555555, 2, 4'b1100, 32'h00000200, 32'h12341234, 32'h00000080, 1'b0);
    doTxn(1'b0, 2'd2, 1'b0, 32'h00000101, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0,        32'h00000080, 1'b1);
    doTxn(1'b0, 2'd1, 1'b1, 32'h00000002, 32'h0,        32'h80017FFF, 1, 4'b1100, 32'h00000000, 32'h0,        32'hFFFF8001, 1'b0);
    doTxn(1'b0, 2'd1, 1'b0, 32'h00000001, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0,        32'hFFFF8001, 1'b1);
    doTxn(1'b0, 2'd3, 1'b0, 32'h00000000, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0,        32'hFFFF8001, 1'b1);
    doTxn(1'b1, 2'd0, 1'b0, 32'h00000001, 32'h000000A5, 32'h0,        1, 4'b0010, 32'h00000000, 32'hA5A5A5A5, 32'hFFFF8001, 1'b0);
    doTxn(1'b1, 2'd2, 1'b0, 32'h000000FC, 32'h01234567, 32'h0,        2, 4'b1111, 32'h000000FC, 32'h01234567, 32'hFFFF8001, 1'b0);
    doTxn(1'b0, 2'd0, 1'b0, 32'h00000002, 32'h0,        32'h12345678, 1, 4'b0100, 32'h00000000, 32'h0,        32'h00000034, 1'b0);
    doTxn(1'b0, 2'd1, 1'b0, 32'h00000000, 32'h0,        32'h1234ABCD, 1, 4'b0011, 32'h00000000, 32'h0,        32'h0000ABCD, 1'b0);
    doTxn(1'b0, 2'd0, 1'b1, 32'h00000001, 32'h0,        32'h0000FE00, 1, 4'b0010, 32'h00000000, 32'h0,        32'hFFFFFFFE, 1'b0);
    doTxn(1'b1, 2'd2, 1'b0, 32'h00000202, 32'h77777777, 32'h0,        1, 4'b0000, 32'h0,        32'h0,        32'hFFFFFFFE, 1'b1);

    // An ack while idle must not disturb anything.
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    repeat (2) @(posedge clock);
    #1 mem_ack = 1'b0;
    @(negedge clock);
    chk("idle_ack_readdata", ReadData, 32'hFFFFFFFE);
    chk1("idle_ack_ready", req_ready, 1'b1);
    @(posedge clock); #1;

`ifdef LSU_TIMEOUT_EN
    // Ack in the very cycle the wait limit is reached: normal completion.
    doTxn(1'b0, 2'd2, 1'b0, 32'h00000040, 32'h0, 32'h11223344, 4, 4'b1111, 32'h00000040, 32'h0, 32'h11223344, 1'b0);
    // No ack at all: mem_en for exactly TIMEOUT cycles, then fault with done.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h00000080; req_wdata = 32'h0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    expWe = 1'b0; expBe = 4'hF; expAddr = 32'h00000080; expWdata = 32'h0; expPhase = P_ACCESS;
    enCnt = 0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clock); if (mem_en) enCnt++;
      @(posedge clock); #1;
    end
    expPhase = P_DONE; expFault = 1'b1;
    chk("timeout_en_cycles", 32'(enCnt), 32'd4);
    @(negedge clock);
    chk1("timeout_fault", fault, 1'b1);
    chk1("timeout_done", done, 1'b1);
    chk("timeout_readdata", ReadData, 32'h11223344);
    @(posedge clock); #1;
    expPhase = P_IDLE; expFault = 1'b0;
`else
    // Without the timeout option a long stall simply waits for the ack.
    doTxn(1'b0, 2'd2, 1'b0, 32'h00000040, 32'h0, 32'h11223344, 300, 4'b1111, 32'h00000040, 32'h0, 32'h11223344, 1'b0);
`endif

    // Reset in the middle of an access aborts it at once, with no done pulse.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h00000300; req_wdata = 32'h0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    expWe = 1'b0; expBe = 4'hF; expAddr = 32'h00000300; expWdata = 32'h0; expPhase = P_ACCESS;
    @(posedge clock); #1;
    #2 reset = 1'b0;
    expPhase = P_IDLE; expRead = 32'h0;
    #1;
    chk1("rst_mid_mem_en", mem_en, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk1("rst_mid_done", done, 1'b0);
    chk1("rst_mid_ready", req_ready, 1'b1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    chk1("rst_release_ready", req_ready, 1'b1);

    doTxn(1'b0, 2'd0, 1'b0, 32'h00000003, 32'h0, 32'hAB000000, 1, 4'b1000, 32'h00000000, 32'h0, 32'h000000AB, 1'b0);

    @(posedge clock); #1;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded %0d time units", 100000);
    $fatal(1);
  end

endmodule
